// File: rtl/fourier_pkg.sv
// Shared types and opcodes for the Fourier sequencer and the n-point Fourier core.
// Used by fourier_seq_ctrl (optional watchdog enabled with FSC_WATCHDOG_EN).
package fourier_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    COMPUTE,
    READ_REQ,
    READ_CAP,
    OUT
  } fsc_state_t;

  localparam logic [1:0] FOUR_OP_IDLE = 2'b00;
  localparam logic [1:0] FOUR_OP_LOAD = 2'b01;
  localparam logic [1:0] FOUR_OP_COMP = 2'b10;
  localparam logic [1:0] FOUR_OP_READ = 2'b11;

  // A one-point frame still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fourier_seq_ctrl_wdog.sv
// COMPUTE-phase watchdog: counts cycles while enabled and flags the LIMIT-th one.
// Instantiated by fourier_seq_ctrl only when FSC_WATCHDOG_EN is defined.
module fsc_wdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Dropping en clears the count, so every COMPUTE entry starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fourier_seq_ctrl.sv
// Frame sequencer for the n-point Fourier core: load samples, compute, stream results.
// Define FSC_WATCHDOG_EN to abort a COMPUTE phase that exceeds WDOG_LIMIT cycles.
module fourier_seq_ctrl
  import fourier_pkg::*;
#(
  parameter int N          = 100,
  parameter int DW         = 64,
  parameter int AW         = 32,
  parameter int WDOG_LIMIT = 6*N*N + 4*N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic          m_last,
  output logic          core_reset,
  output logic [1:0]    core_op,
  output logic [AW-1:0] core_addr,
  output logic [DW-1:0] core_x,
  input  logic [DW-1:0] core_y_re,
  input  logic [DW-1:0] core_y_im,
  input  logic          core_done,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          error
);

  localparam int            IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N < 1 || WDOG_LIMIT < 1) begin : g_param_check
    $error("fourier_seq_ctrl: N and WDOG_LIMIT must both be at least 1");
  end

  fsc_state_t    state;
  logic [IW-1:0] idx;
  logic          wdog_expired;

`ifdef FSC_WATCHDOG_EN
  fsc_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .en      (state == COMPUTE),
    .expired (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  // Main sequencer; idx is reused as sample index while loading and result index while reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      idx       <= '0;
      m_valid   <= 1'b0;
      m_re      <= '0;
      m_im      <= '0;
      frame_cnt <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (s_valid) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= COMPUTE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        COMPUTE: begin
          if (core_done) begin
            state <= READ_REQ;
          end else if (wdog_expired) begin
            error <= 1'b1;
            idx   <= '0;
            state <= CLEAR;
          end
        end
        READ_REQ: begin
          state <= READ_CAP;
        end
        READ_CAP: begin
          m_re    <= core_y_re;
          m_im    <= core_y_im;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (idx == LAST) begin
              idx       <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= CLEAR;
            end else begin
              idx   <= idx + IW'(1);
              state <= READ_REQ;
            end
          end
        end
        default: begin
          idx   <= '0;
          state <= CLEAR;
        end
      endcase
    end
  end

  // Load opcode follows s_valid directly so a sample is written in its handshake cycle.
  always_comb begin
    core_op = FOUR_OP_IDLE;
    core_x  = '0;
    case (state)
      LOAD: begin
        if (s_valid) begin
          core_op = FOUR_OP_LOAD;
          core_x  = s_data;
        end
      end
      COMPUTE:  core_op = FOUR_OP_COMP;
      READ_REQ: core_op = FOUR_OP_READ;
      default:  core_op = FOUR_OP_IDLE;
    endcase
  end

  assign core_addr  = AW'(idx);
  assign s_ready    = (state == LOAD);
  assign core_reset = (state == CLEAR);
  assign busy       = (state != LOAD) || (idx != '0);
  assign m_last     = (state == OUT) && (idx == LAST);

endmodule

// File: tb/tb_fourier_seq_ctrl.sv
// Self-checking bench for fourier_seq_ctrl with a small behavioural core (LUT re=1, im=0).
// Watchdog expectations follow FSC_WATCHDOG_EN.
module tb_fourier_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int WL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_re;
  logic [DW-1:0] m_im;
  logic          m_last;
  logic          core_reset;
  logic [1:0]    core_op;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_x;
  logic [DW-1:0] core_y_re = '0;
  logic [DW-1:0] core_y_im = '0;
  logic          core_done = 1'b0;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          error;

  always #5 clk = ~clk;

  fourier_seq_ctrl #(
    .N          (N),
    .DW         (DW),
    .AW         (AW),
    .WDOG_LIMIT (WL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_re       (m_re),
    .m_im       (m_im),
    .m_last     (m_last),
    .core_reset (core_reset),
    .core_op    (core_op),
    .core_addr  (core_addr),
    .core_x     (core_x),
    .core_y_re  (core_y_re),
    .core_y_im  (core_y_im),
    .core_done  (core_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .error      (error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural core: every result is the plain sum of the loaded samples.
  logic [DW-1:0] core_mem [N];
  int            comp_cycles = 0;
  bit            done_enable = 1'b1;
  int            load_addr_q[$];

  always @(posedge clk) begin
    if (core_reset) begin
      for (int i = 0; i < N; i++) core_mem[i] <= '0;
      comp_cycles <= 0;
      core_done   <= 1'b0;
    end else begin
      case (core_op)
        2'b01: begin
          core_mem[core_addr[1:0]] <= core_x;
          load_addr_q.push_back(int'(core_addr));
        end
        2'b10: begin
          comp_cycles <= comp_cycles + 1;
          if (done_enable && comp_cycles >= 4) core_done <= 1'b1;
        end
        2'b11: begin
          core_y_re <= core_mem[0] + core_mem[1] + core_mem[2] + core_mem[3];
          core_y_im <= '0;
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   exp_load_idx = 0;
  int   cr_cycles    = 0;

  // Monitor sits on the falling edge, where inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_reset) cr_cycles++;
      if (s_ready) begin
        if (s_valid) begin
          check_output("load_op", 64'(core_op), 64'd1);
          check_output("load_addr", 64'(core_addr), 64'(exp_load_idx));
          check_output("load_x", core_x, s_data);
          exp_load_idx = (exp_load_idx + 1) % N;
        end else begin
          check_output("gap_op_idle", 64'(core_op), 64'd0);
        end
      end
      if (m_valid) begin
        check_output("no_core_op_in_out", 64'(core_op), 64'd0);
        if (m_ready) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_result", 64'd1, 64'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check_output("m_re", m_re, mon_e.re);
            check_output("m_im", m_im, mon_e.im);
            check_output("m_last", 64'(m_last), 64'(mon_e.last));
          end
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] smp [N];
    bit            gaps;
    bit            bp;
    logic [DW-1:0] exp_re;
  } frame_vec_t;

  frame_vec_t vec [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] smp [N], input bit gaps);
    int t;
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = smp[i];
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) check_output("s_ready_timeout", 64'd0, 64'd1);
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic push_expected(input logic [DW-1:0] re);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.re   = re;
      e.im   = '0;
      e.last = (k == N - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    check_output("drain_timeout", 64'(sb_q.size()), 64'd0);
    tick();
    check_output("idle_busy", 64'(busy), 64'd0);
    check_output("idle_s_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic check_load_addrs();
    check_output("load_count", 64'(load_addr_q.size()), 64'(N));
    for (int k = 0; k < N && k < load_addr_q.size(); k++)
      check_output("load_addr_seq", 64'(load_addr_q[k]), 64'(k));
    load_addr_q.delete();
  endtask

  task automatic wait_negedge_for_op(input logic [1:0] op, output bit found);
    int t = 0;
    @(negedge clk);
    while (core_op != op && t < 200) begin
      @(negedge clk);
      t++;
    end
    found = (core_op == op);
    if (!found) check_output("op_wait_timeout", 64'(core_op), 64'(op));
  endtask

  task automatic backpressure_check(input logic [DW-1:0] re);
    int t = 0;
    @(negedge clk);
    while (!m_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_output("bp_first_valid", 64'(m_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check_output("bp_hold_valid", 64'(m_valid), 64'd1);
      check_output("bp_hold_re", m_re, re);
      check_output("bp_hold_last", 64'(m_last), 64'd0);
    end
    tick();
    m_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit found;
    int cnt;

    vec[0].smp = '{64'd1, 64'd2, 64'd3, 64'd4}; vec[0].gaps = 1'b0; vec[0].bp = 1'b0; vec[0].exp_re = 64'd10;
    vec[1].smp = '{64'd1, 64'd2, 64'd3, 64'd4}; vec[1].gaps = 1'b1; vec[1].bp = 1'b0; vec[1].exp_re = 64'd10;
    vec[2].smp = '{64'd1, 64'd2, 64'd3, 64'd4}; vec[2].gaps = 1'b0; vec[2].bp = 1'b1; vec[2].exp_re = 64'd10;
    vec[3].smp = '{64'd5, 64'd5, 64'd5, 64'd5}; vec[3].gaps = 1'b0; vec[3].bp = 1'b0; vec[3].exp_re = 64'd20;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) tick();
    check_output("rst_s_ready", 64'(s_ready), 64'd0);
    check_output("rst_core_reset", 64'(core_reset), 64'd1);
    check_output("rst_busy", 64'(busy), 64'd1);
    check_output("rst_core_op", 64'(core_op), 64'd0);
    check_output("rst_m_valid", 64'(m_valid), 64'd0);
    check_output("rst_m_re", m_re, 64'd0);
    check_output("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    tick();
    check_output("post_rst_s_ready", 64'(s_ready), 64'd1);
    check_output("post_rst_busy", 64'(busy), 64'd0);

    // Single frame, input gaps, backpressure, then a back-to-back frame of fives.
    for (int f = 0; f < 4; f++) begin
      load_addr_q.delete();
      push_expected(vec[f].exp_re);
      m_ready = !vec[f].bp;
      apply_stimulus(vec[f].smp, vec[f].gaps);
      if (vec[f].bp) backpressure_check(vec[f].exp_re);
      wait_drain();
      check_load_addrs();
      check_output("frame_cnt", 64'(frame_cnt), 64'(f + 1));
      check_output("core_reset_pulses", 64'(cr_cycles), 64'(f + 2));
    end

    // Reset in the middle of COMPUTE discards the frame.
    apply_stimulus(vec[0].smp, 1'b0);
    wait_negedge_for_op(2'b10, found);
    #1;
    reset = 1'b1;
    #1;
    check_output("midrst_m_valid", 64'(m_valid), 64'd0);
    check_output("midrst_m_re", m_re, 64'd0);
    check_output("midrst_m_im", m_im, 64'd0);
    check_output("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("midrst_core_op", 64'(core_op), 64'd0);
    check_output("midrst_core_reset", 64'(core_reset), 64'd1);
    check_output("midrst_s_ready", 64'(s_ready), 64'd0);
    check_output("midrst_error", 64'(error), 64'd0);
    tick();
    reset = 1'b0;
    load_addr_q.delete();
    push_expected(64'd4);
    apply_stimulus('{64'd1, 64'd1, 64'd1, 64'd1}, 1'b0);
    wait_drain();
    check_load_addrs();
    check_output("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    // Core never signals done.
    done_enable = 1'b0;
    apply_stimulus(vec[0].smp, 1'b0);
    wait_negedge_for_op(2'b10, found);
    cnt = 0;
    while (core_op == 2'b10 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
`ifdef FSC_WATCHDOG_EN
    check_output("wdog_compute_cycles", 64'(cnt), 64'(WL));
    check_output("wdog_error", 64'(error), 64'd1);
    check_output("wdog_clear", 64'(core_reset), 64'd1);
    @(negedge clk);
    check_output("wdog_load", 64'(s_ready), 64'd1);
    check_output("wdog_error_sticky", 64'(error), 64'd1);
    check_output("wdog_no_m_valid", 64'(m_valid), 64'd0);
    check_output("wdog_frame_cnt", 64'(frame_cnt), 64'd1);
`else
    check_output("nowdog_compute_cycles", 64'(cnt), 64'd100);
    check_output("nowdog_core_op", 64'(core_op), 64'd2);
    check_output("nowdog_error", 64'(error), 64'd0);
    check_output("nowdog_frame_cnt", 64'(frame_cnt), 64'd1);
`endif
    check_output("leftover_results", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
